// File: rtl/bike_trail_engine_if.sv
// rtl/bike_trail_engine_if.sv - grid RAM port bundle between the game engine and the cell-grid RAM
//
// Signals:
//   ram_addr   grid RAM address, y*GRID_W + x
//   ram_wdata  colour index to write
//   ram_we     write enable
//   ram_rdata  registered read data, valid one cycle after ram_addr with ram_we=0
// Modports: master (engine side), slave (RAM side).

interface bike_trail_engine_if #(
  parameter int ADDR_W = 13
);
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_wdata;
  logic              ram_we;
  logic [7:0]        ram_rdata;

  modport master (output ram_addr, output ram_wdata, output ram_we, input ram_rdata);
  modport slave  (input ram_addr, input ram_wdata, input ram_we, output ram_rdata);
endinterface

// File: rtl/bike_trail_engine.sv
// rtl/bike_trail_engine.sv - two-player light-bike game step engine owning the grid RAM write side
//
// Ports:
//   i_clock      system clock, shared with the grid RAM
//   i_reset      synchronous, active-high reset
//   i_start      one-cycle pulse, starts (or restarts) a game
//   i_tick       one-cycle pulse, requests one game step
//   i_p1_dir     player 1 direction request (00 up, 01 right, 10 down, 11 left)
//   i_p2_dir     player 2 direction request
//   ram          grid RAM port (bike_trail_engine_if.master)
//   o_busy       high except in IDLE, WAIT_TICK and OVER
//   o_game_over  high in OVER
//   o_winner     00 none, 01 P1, 10 P2, 11 draw
//
// Optional feature macro: BIKE_WRAP_EN (no border, coordinates wrap around the grid).

module bike_trail_engine #(
  parameter int         GRID_W     = 80,
  parameter int         GRID_H     = 60,
  parameter int         ADDR_W     = 13,
  parameter logic [7:0] P1_COLOR   = 8'd1,
  parameter logic [7:0] P2_COLOR   = 8'd2,
  parameter logic [7:0] WALL_COLOR = 8'd3
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic                       i_tick,
  input  logic [1:0]                 i_p1_dir,
  input  logic [1:0]                 i_p2_dir,
  bike_trail_engine_if.master        ram,
  output logic                       o_busy,
  output logic                       o_game_over,
  output logic [1:0]                 o_winner
);

  localparam int X_W   = $clog2(GRID_W);
  localparam int Y_W   = $clog2(GRID_H);
  localparam int CELLS = GRID_W * GRID_H;

  localparam logic [X_W-1:0] P1_X0 = X_W'(GRID_W / 4);
  localparam logic [X_W-1:0] P2_X0 = X_W'(3 * GRID_W / 4);
  localparam logic [Y_W-1:0] Y0    = Y_W'(GRID_H / 2);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

`ifdef BIKE_WRAP_EN
  localparam logic [7:0] BORDER_COLOR = 8'd0;
`else
  localparam logic [7:0] BORDER_COLOR = WALL_COLOR;
`endif

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_CLEAR     = 4'd1;
  localparam logic [3:0] S_PLACE1    = 4'd2;
  localparam logic [3:0] S_PLACE2    = 4'd3;
  localparam logic [3:0] S_WAIT_TICK = 4'd4;
  localparam logic [3:0] S_MOVE      = 4'd5;
  localparam logic [3:0] S_READ1     = 4'd6;
  localparam logic [3:0] S_CHK1      = 4'd7;
  localparam logic [3:0] S_READ2     = 4'd8;
  localparam logic [3:0] S_CHK2      = 4'd9;
  localparam logic [3:0] S_RESOLVE   = 4'd10;
  localparam logic [3:0] S_WRITE1    = 4'd11;
  localparam logic [3:0] S_WRITE2    = 4'd12;
  localparam logic [3:0] S_OVER      = 4'd13;

  logic [3:0]        r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [X_W-1:0]    r_cx;
  logic [Y_W-1:0]    r_cy;
  logic [X_W-1:0]    r_p1_x, r_p2_x, r_n1_x, r_n2_x;
  logic [Y_W-1:0]    r_p1_y, r_p2_y, r_n1_y, r_n2_y;
  logic [1:0]        r_p1_hd, r_p2_hd;
  logic              r_c1, r_c2;
  logic              r_tick_pending;
  logic [1:0]        r_winner;

  logic [1:0]        w_p1_hd, w_p2_hd;
  logic [ADDR_W-1:0] w_n1_addr, w_n2_addr;
  logic              w_border;
  logic              w_head_on;
  logic              w_crash1, w_crash2;

  // A request for the exact reverse of the current heading is dropped.
  function automatic logic [1:0] pick_dir(input logic [1:0] cur, input logic [1:0] req);
    return (req == (cur ^ 2'b10)) ? cur : req;
  endfunction

  function automatic logic [X_W-1:0] step_x(input logic [X_W-1:0] x, input logic [1:0] d);
    logic [X_W-1:0] nx;
    nx = x;
`ifdef BIKE_WRAP_EN
    if (d == DIR_RIGHT)     nx = (x == X_W'(GRID_W - 1)) ? '0 : x + 1'b1;
    else if (d == DIR_LEFT) nx = (x == '0) ? X_W'(GRID_W - 1) : x - 1'b1;
`else
    // Walls stop heads before they reach the edge, so no range guard is needed.
    if (d == DIR_RIGHT)     nx = x + 1'b1;
    else if (d == DIR_LEFT) nx = x - 1'b1;
`endif
    return nx;
  endfunction

  function automatic logic [Y_W-1:0] step_y(input logic [Y_W-1:0] y, input logic [1:0] d);
    logic [Y_W-1:0] ny;
    ny = y;
`ifdef BIKE_WRAP_EN
    if (d == DIR_DOWN)    ny = (y == Y_W'(GRID_H - 1)) ? '0 : y + 1'b1;
    else if (d == DIR_UP) ny = (y == '0) ? Y_W'(GRID_H - 1) : y - 1'b1;
`else
    if (d == DIR_DOWN)    ny = y + 1'b1;
    else if (d == DIR_UP) ny = y - 1'b1;
`endif
    return ny;
  endfunction

  function automatic logic [ADDR_W-1:0] to_addr(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return ADDR_W'(y) * ADDR_W'(GRID_W) + ADDR_W'(x);
  endfunction

  assign w_p1_hd   = pick_dir(r_p1_hd, i_p1_dir);
  assign w_p2_hd   = pick_dir(r_p2_hd, i_p2_dir);
  assign w_n1_addr = to_addr(r_n1_x, r_n1_y);
  assign w_n2_addr = to_addr(r_n2_x, r_n2_y);
  assign w_border  = (r_cx == '0) || (r_cx == X_W'(GRID_W - 1)) ||
                     (r_cy == '0) || (r_cy == Y_W'(GRID_H - 1));
  assign w_head_on = (r_n1_x == r_n2_x) && (r_n1_y == r_n2_y);
  assign w_crash1  = r_c1 | w_head_on;
  assign w_crash2  = r_c2 | w_head_on;

  assign o_busy      = !((r_state == S_IDLE) || (r_state == S_WAIT_TICK) || (r_state == S_OVER));
  assign o_game_over = (r_state == S_OVER);
  assign o_winner    = r_winner;

  always_comb begin
    ram.ram_we    = 1'b0;
    ram.ram_addr  = '0;
    ram.ram_wdata = 8'd0;
    case (r_state)
      S_CLEAR: begin
        ram.ram_we    = 1'b1;
        ram.ram_addr  = r_cnt;
        ram.ram_wdata = w_border ? BORDER_COLOR : 8'd0;
      end
      S_PLACE1: begin
        ram.ram_we    = 1'b1;
        ram.ram_addr  = to_addr(P1_X0, Y0);
        ram.ram_wdata = P1_COLOR;
      end
      S_PLACE2: begin
        ram.ram_we    = 1'b1;
        ram.ram_addr  = to_addr(P2_X0, Y0);
        ram.ram_wdata = P2_COLOR;
      end
      S_READ1: ram.ram_addr = w_n1_addr;
      S_READ2: ram.ram_addr = w_n2_addr;
      S_WRITE1: begin
        ram.ram_we    = 1'b1;
        ram.ram_addr  = w_n1_addr;
        ram.ram_wdata = P1_COLOR;
      end
      S_WRITE2: begin
        ram.ram_we    = 1'b1;
        ram.ram_addr  = w_n2_addr;
        ram.ram_wdata = P2_COLOR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_cx           <= '0;
      r_cy           <= '0;
      r_p1_x         <= '0;
      r_p1_y         <= '0;
      r_p2_x         <= '0;
      r_p2_y         <= '0;
      r_n1_x         <= '0;
      r_n1_y         <= '0;
      r_n2_x         <= '0;
      r_n2_y         <= '0;
      r_p1_hd        <= DIR_RIGHT;
      r_p2_hd        <= DIR_LEFT;
      r_c1           <= 1'b0;
      r_c2           <= 1'b0;
      r_tick_pending <= 1'b0;
      r_winner       <= 2'b00;
    end else begin
      // One step of look-ahead only; a second early tick is lost.
      if (i_tick && o_busy) r_tick_pending <= 1'b1;

      if (i_start) begin
        r_state        <= S_CLEAR;
        r_cnt          <= '0;
        r_cx           <= '0;
        r_cy           <= '0;
        r_winner       <= 2'b00;
        r_tick_pending <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: ;
          S_CLEAR: begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cx == X_W'(GRID_W - 1)) begin
              r_cx <= '0;
              r_cy <= r_cy + 1'b1;
            end else begin
              r_cx <= r_cx + 1'b1;
            end
            if (r_cnt == ADDR_W'(CELLS - 1)) r_state <= S_PLACE1;
          end
          S_PLACE1: begin
            r_p1_x  <= P1_X0;
            r_p1_y  <= Y0;
            r_p1_hd <= DIR_RIGHT;
            r_state <= S_PLACE2;
          end
          S_PLACE2: begin
            r_p2_x  <= P2_X0;
            r_p2_y  <= Y0;
            r_p2_hd <= DIR_LEFT;
            r_state <= S_WAIT_TICK;
          end
          S_WAIT_TICK: begin
            if (i_tick || r_tick_pending) begin
              r_tick_pending <= 1'b0;
              r_state        <= S_MOVE;
            end
          end
          S_MOVE: begin
            r_p1_hd <= w_p1_hd;
            r_p2_hd <= w_p2_hd;
            r_n1_x  <= step_x(r_p1_x, w_p1_hd);
            r_n1_y  <= step_y(r_p1_y, w_p1_hd);
            r_n2_x  <= step_x(r_p2_x, w_p2_hd);
            r_n2_y  <= step_y(r_p2_y, w_p2_hd);
            r_state <= S_READ1;
          end
          S_READ1: r_state <= S_CHK1;
          S_CHK1: begin
            r_c1    <= |ram.ram_rdata;
            r_state <= S_READ2;
          end
          S_READ2: r_state <= S_CHK2;
          S_CHK2: begin
            r_c2    <= |ram.ram_rdata;
            r_state <= S_RESOLVE;
          end
          S_RESOLVE: begin
            if (w_crash1 || w_crash2) begin
              r_winner <= {w_crash1, w_crash2};
              r_state  <= S_OVER;
            end else begin
              r_state <= S_WRITE1;
            end
          end
          S_WRITE1: begin
            r_p1_x  <= r_n1_x;
            r_p1_y  <= r_n1_y;
            r_state <= S_WRITE2;
          end
          S_WRITE2: begin
            r_p2_x  <= r_n2_x;
            r_p2_y  <= r_n2_y;
            r_state <= S_WAIT_TICK;
          end
          S_OVER: ;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bike_trail_engine.sv
// tb/tb_bike_trail_engine.sv - directed self-checking bench for bike_trail_engine

module tb_bike_trail_engine;

  logic       clk;
  logic       reset;
  logic       start;
  logic       tick;
  logic [1:0] p1_dir;
  logic [1:0] p2_dir;
  logic       busy;
  logic       game_over;
  logic [1:0] winner;

  bike_trail_engine_if #(.ADDR_W(13)) bus ();

  bike_trail_engine dut (
    .i_clock     (clk),
    .i_reset     (reset),
    .i_start     (start),
    .i_tick      (tick),
    .i_p1_dir    (p1_dir),
    .i_p2_dir    (p2_dir),
    .ram         (bus),
    .o_busy      (busy),
    .o_game_over (game_over),
    .o_winner    (winner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] mem [0:8191];

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8192; i++) mem[i] <= 8'hAA;
    end else if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  int          s_nw;
  logic [31:0] s_wa [2];
  logic [31:0] s_wd [2];
  logic [31:0] s_rd1, s_rd2;
  int          s_len;

  // One game step: optional tick pulse, then sample each cycle until busy drops.
  task automatic run_step(input bit do_tick, input bit extra, input logic [1:0] d1, input logic [1:0] d2);
    p1_dir = d1;
    p2_dir = d2;
    tick   = do_tick;
    @(negedge clk);
    tick  = 1'b0;
    s_nw  = 0;
    s_len = -1;
    s_rd1 = '1;
    s_rd2 = '1;
    s_wa[0] = '1; s_wa[1] = '1; s_wd[0] = '1; s_wd[1] = '1;
    for (int k = 0; k < 16; k++) begin
      if (bus.ram_we === 1'b1) begin
        if (s_nw < 2) begin
          s_wa[s_nw] = 32'(bus.ram_addr);
          s_wd[s_nw] = 32'(bus.ram_wdata);
        end
        s_nw++;
      end
      if (k == 1) s_rd1 = 32'(bus.ram_addr);
      if (k == 3) s_rd2 = 32'(bus.ram_addr);
      if (busy === 1'b0) begin
        s_len = k;
        break;
      end
      tick = extra && (k == 2 || k == 4);
      @(negedge clk);
    end
    tick = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ok, n_bad, n_good, n_wait, n_busy;
    int x, y;
    logic [7:0] exp_d;
    logic [7:0] wall;
`ifdef BIKE_WRAP_EN
    wall = 8'd0;
`else
    wall = 8'd3;
`endif

    reset = 1'b1; start = 1'b0; tick = 1'b0; p1_dir = 2'b01; p2_dir = 2'b11;
    repeat (3) @(negedge clk);
    chk("reset_we", 32'(bus.ram_we), 32'd0);
    chk("reset_addr", 32'(bus.ram_addr), 32'd0);
    chk("reset_wdata", 32'(bus.ram_wdata), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_game_over", 32'(game_over), 32'd0);
    chk("reset_winner", 32'(winner), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    tick = 1'b1; @(negedge clk); tick = 1'b0; @(negedge clk);
    chk("idle_tick_busy", 32'(busy), 32'd0);

    start = 1'b1; @(negedge clk); start = 1'b0;
    n_ok = 0; n_bad = 0;
    for (int i = 0; i < 4800; i++) begin
      x = i % 80; y = i / 80;
      exp_d = (x == 0 || x == 79 || y == 0 || y == 59) ? wall : 8'd0;
      if (bus.ram_we === 1'b1 && bus.ram_addr === 13'(i)) n_ok++;
      if (bus.ram_wdata !== exp_d) n_bad++;
      @(negedge clk);
    end
    chk("clear_write_cycles", 32'(n_ok), 32'd4800);
    chk("clear_data_errors", 32'(n_bad), 32'd0);
    chk("clear_mem0", 32'(mem[0]), 32'(wall));
    chk("clear_mem81", 32'(mem[81]), 32'd0);
    chk("clear_mem4799", 32'(mem[4799]), 32'(wall));
    chk("place1_we", 32'(bus.ram_we), 32'd1);
    chk("place1_addr", 32'(bus.ram_addr), 32'd2420);
    chk("place1_data", 32'(bus.ram_wdata), 32'd1);
    @(negedge clk);
    chk("place2_addr", 32'(bus.ram_addr), 32'd2460);
    chk("place2_data", 32'(bus.ram_wdata), 32'd2);
    @(negedge clk);
    chk("place_busy_low", 32'(busy), 32'd0);

    run_step(1'b1, 1'b0, 2'b01, 2'b11);
    chk("step1_read1", s_rd1, 32'd2421);
    chk("step1_read2", s_rd2, 32'd2459);
    chk("step1_nwrites", 32'(s_nw), 32'd2);
    chk("step1_wa1", s_wa[0], 32'd2421);
    chk("step1_wd1", s_wd[0], 32'd1);
    chk("step1_wa2", s_wa[1], 32'd2459);
    chk("step1_wd2", s_wd[1], 32'd2);
    chk("step1_len", 32'(s_len), 32'd8);

    run_step(1'b1, 1'b0, 2'b11, 2'b11);
    chk("reverse_wa1", s_wa[0], 32'd2422);
    chk("reverse_wa2", s_wa[1], 32'd2458);

    n_good = 0;
    for (int k = 0; k < 17; k++) begin
      run_step(1'b1, 1'b0, 2'b01, 2'b11);
      if (s_nw == 2 && s_wa[0] == 32'(2423 + k) && s_wa[1] == 32'(2457 - k) && s_len == 8) n_good++;
    end
    chk("approach_steps", 32'(n_good), 32'd17);

    run_step(1'b1, 1'b0, 2'b01, 2'b11);
    chk("headon_read1", s_rd1, 32'd2440);
    chk("headon_read2", s_rd2, 32'd2440);
    chk("headon_nwrites", 32'(s_nw), 32'd0);
    chk("headon_len", 32'(s_len), 32'd6);
    chk("headon_game_over", 32'(game_over), 32'd1);
    chk("headon_winner", 32'(winner), 32'd3);

    tick = 1'b1; @(negedge clk); tick = 1'b0; @(negedge clk);
    chk("over_tick_busy", 32'(busy), 32'd0);
    chk("over_tick_hold", 32'(game_over), 32'd1);

    start = 1'b1; @(negedge clk); start = 1'b0;
    chk("restart_game_over", 32'(game_over), 32'd0);
    chk("restart_winner", 32'(winner), 32'd0);
    n_wait = 0;
    for (int i = 0; i < 6000; i++) begin
      if (busy === 1'b0) break;
      n_wait++;
      @(negedge clk);
    end
    chk("restart_setup_cycles", 32'(n_wait), 32'd4802);

    run_step(1'b1, 1'b1, 2'b00, 2'b11);
    chk("up1_wa1", s_wa[0], 32'd2340);
    chk("up1_len", 32'(s_len), 32'd8);
    run_step(1'b0, 1'b0, 2'b00, 2'b11);
    chk("pending_wa1", s_wa[0], 32'd2260);
    chk("pending_wa2", s_wa[1], 32'd2458);
    chk("pending_len", 32'(s_len), 32'd8);
    n_busy = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy !== 1'b0) n_busy++;
    end
    chk("third_tick_dropped", 32'(n_busy), 32'd0);

    n_good = 0;
    for (int k = 0; k < 27; k++) begin
      run_step(1'b1, 1'b0, 2'b00, 2'b11);
      if (s_nw == 2 && s_wa[0] == 32'((27 - k) * 80 + 20) && s_wa[1] == 32'(2400 + 57 - k) && s_len == 8) n_good++;
    end
    chk("up_run_steps", 32'(n_good), 32'd27);

    run_step(1'b1, 1'b0, 2'b00, 2'b11);
`ifdef BIKE_WRAP_EN
    chk("wrap_y0_addr", s_wa[0], 32'd20);
    chk("wrap_y0_len", 32'(s_len), 32'd8);
    run_step(1'b1, 1'b0, 2'b00, 2'b11);
    chk("wrap_y59_addr", s_wa[0], 32'd4740);
    chk("wrap_y59_game_over", 32'(game_over), 32'd0);
`else
    chk("wall_read1", s_rd1, 32'd20);
    chk("wall_nwrites", 32'(s_nw), 32'd0);
    chk("wall_game_over", 32'(game_over), 32'd1);
    chk("wall_winner", 32'(winner), 32'd2);
`endif

    start = 1'b1; @(negedge clk); start = 1'b0;
    repeat (100) @(negedge clk);
    reset = 1'b1; start = 1'b1; tick = 1'b1;
    @(negedge clk);
    reset = 1'b0; start = 1'b0; tick = 1'b0;
    chk("midclear_reset_busy", 32'(busy), 32'd0);
    chk("midclear_reset_we", 32'(bus.ram_we), 32'd0);
    chk("midclear_reset_addr", 32'(bus.ram_addr), 32'd0);
    chk("midclear_reset_game_over", 32'(game_over), 32'd0);
    tick = 1'b1; @(negedge clk); tick = 1'b0; @(negedge clk);
    chk("post_reset_tick_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
